// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared state encoding and constants for the restoring divider
package divider_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = 5;

  localparam logic [DIV_WIDTH-1:0] INT_MIN   = 32'h8000_0000;
  localparam logic [DIV_WIDTH-1:0] NEG_ONE   = 32'hFFFF_FFFF;
  localparam logic [CNT_W-1:0]     ITER_LAST = 5'(DIV_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

  // Magnitude as unsigned; INT_MIN maps onto itself, which is 2^31 unsigned.
  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] x);
    return x[DIV_WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/divider_div_step.sv
// rtl/divider_div_step.sv - one combinational restoring-division iteration
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dvd_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  logic [WIDTH-1:0] w_rem_shift;
  logic [WIDTH:0]   w_diff;

  // The remainder stays below the divisor (<= 2^31), so its MSB is always clear before the shift.
  assign w_rem_shift = {i_rem[WIDTH-2:0], i_dvd_msb};
  assign w_diff      = {1'b0, w_rem_shift} - {1'b0, i_divisor};
  assign o_q_bit     = ~w_diff[WIDTH];
  assign o_rem       = o_q_bit ? w_diff[WIDTH-1:0] : w_rem_shift;

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - multi-cycle signed restoring divider with start/ready/running handshake
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             div_ready,
  output logic             div_running
);

  div_state_t       r_state;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_result;
  logic             r_sign_q;
  logic             r_ovf;
  logic             r_exc;
  logic             r_ready;
  logic             r_running;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_rem_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_quot_signed;
  logic             w_div_zero;

  assign w_div_zero    = (data_operandB == '0);
  assign w_quot_signed = r_sign_q ? (~r_quot + 1'b1) : r_quot;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_dvd_msb (r_dvd[WIDTH-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_rem_next),
    .o_q_bit   (w_q_bit)
  );

  // Iteration counter; a start pulse restarts it from any state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (ctrl_DIV) begin
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 5'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_result  <= '0;
      r_sign_q  <= 1'b0;
      r_ovf     <= 1'b0;
      r_exc     <= 1'b0;
      r_ready   <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (ctrl_DIV) begin
        // Start (or abort-and-restart) from any state.
        r_dvd     <= abs_val(data_operandA);
        r_dvs     <= abs_val(data_operandB);
        r_sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        r_ovf     <= (data_operandA == INT_MIN) && (data_operandB == NEG_ONE);
        r_rem     <= '0;
        r_quot    <= '0;
        r_running <= 1'b1;
        if (w_div_zero) begin
          r_state  <= S_DONE;
          r_result <= '0;
          r_exc    <= 1'b1;
          r_ready  <= 1'b1;
        end else begin
          r_state <= S_RUN;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            r_running <= 1'b0;
          end
          S_RUN: begin
            r_rem  <= w_rem_next;
            r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
            r_quot <= {r_quot[WIDTH-2:0], w_q_bit};
            if (r_cnt == ITER_LAST) begin
              r_state <= S_FIX;
            end
          end
          S_FIX: begin
            r_result <= r_ovf ? INT_MIN : w_quot_signed;
            r_exc    <= r_ovf;
            r_ready  <= 1'b1;
            r_state  <= S_DONE;
          end
          S_DONE: begin
            r_running <= 1'b0;
            r_state   <= S_IDLE;
          end
          default: begin
            r_running <= 1'b0;
            r_state   <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign div_ready      = r_ready;
  assign div_running    = r_running;

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - directed self-checking bench for the divider
module tb_divider;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        div_ready;
  logic        div_running;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] last_res = '0;

  divider dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .div_ready      (div_ready),
    .div_running    (div_running)
  );

  always #5 clock = ~clock;

  // Called at a negedge: drives a start pulse there (cycle 0) and observes cycles 1..max_cyc.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int exp_done,
                        input logic [31:0] prev_res, input int max_cyc,
                        output int rdy_cyc, output int rdy_cnt, output int run_err,
                        output int hold_err, output logic [31:0] res, output logic exc);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV = 1'b1;
    rdy_cyc = -1;
    rdy_cnt = 0;
    run_err = 0;
    hold_err = 0;
    res = 'x;
    exc = 1'bx;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge clock);
      if (cyc == 1) ctrl_DIV = 1'b0;
      if (div_running !== (cyc <= exp_done)) run_err++;
      if (cyc < exp_done && data_result !== prev_res) hold_err++;
      if (div_ready === 1'b1) begin
        rdy_cnt++;
        if (rdy_cyc < 0) begin
          rdy_cyc = cyc;
          res = data_result;
          exc = data_exception;
        end
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    total_cnt++; if (data_result !== 32'h0) $display("FAIL reset_result got %h want 0", data_result); else pass_cnt++;
    total_cnt++; if (data_exception !== 1'b0) $display("FAIL reset_exc got %b want 0", data_exception); else pass_cnt++;
    total_cnt++; if (div_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", div_ready); else pass_cnt++;
    total_cnt++; if (div_running !== 1'b0) $display("FAIL reset_running got %b want 0", div_running); else pass_cnt++;
    reset_n = 1'b1;
    @(negedge clock);
    last_res = 32'h0;
  endtask

  task automatic test_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input int exp_done, input logic [31:0] exp_res, input logic exp_exc);
    int rc, rn, re, he;
    logic [31:0] res;
    logic exc;
    run_op(a, b, exp_done, last_res, 40, rc, rn, re, he, res, exc);
    total_cnt++; if (rc !== exp_done) $display("FAIL %s ready_cycle got %0d want %0d", name, rc, exp_done); else pass_cnt++;
    total_cnt++; if (rn !== 1) $display("FAIL %s ready_pulses got %0d want 1", name, rn); else pass_cnt++;
    total_cnt++; if (re !== 0) $display("FAIL %s running_window got %0d bad cycles want 0", name, re); else pass_cnt++;
    total_cnt++; if (he !== 0) $display("FAIL %s result_hold got %0d bad cycles want 0", name, he); else pass_cnt++;
    total_cnt++; if (res !== exp_res) $display("FAIL %s result got %h want %h", name, res, exp_res); else pass_cnt++;
    total_cnt++; if (exc !== exp_exc) $display("FAIL %s exception got %b want %b", name, exc, exp_exc); else pass_cnt++;
    last_res = exp_res;
  endtask

  task automatic test_basic;
    test_op("pos_pos", 32'd7, 32'd2, 34, 32'd3, 1'b0);
  endtask

  task automatic test_signs;
    test_op("neg_pos", 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, 1'b0);
    test_op("pos_neg", 32'd7, 32'hFFFF_FFFE, 34, 32'hFFFF_FFFD, 1'b0);
    test_op("neg_neg", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 34, 32'd3, 1'b0);
  endtask

  task automatic test_div_zero;
    test_op("div_zero", 32'd5, 32'd0, 1, 32'd0, 1'b1);
  endtask

  task automatic test_overflow;
    test_op("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, 1'b1);
    test_op("intmin_by_one", 32'h8000_0000, 32'd1, 34, 32'h8000_0000, 1'b0);
  endtask

  task automatic test_restart;
    int early_rdy;
    early_rdy = 0;
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    ctrl_DIV = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clock);
      if (cyc == 1) ctrl_DIV = 1'b0;
      if (div_ready === 1'b1) early_rdy++;
    end
    @(negedge clock);
    total_cnt++; if (early_rdy !== 0) $display("FAIL restart_early_ready got %0d want 0", early_rdy); else pass_cnt++;
    test_op("restart", 32'd9, 32'd3, 34, 32'd3, 1'b0);
  endtask

  task automatic test_reset_mid;
    int rdy_seen;
    rdy_seen = 0;
    data_operandA = 32'd1000;
    data_operandB = 32'd10;
    ctrl_DIV = 1'b1;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clock);
      if (cyc == 1) ctrl_DIV = 1'b0;
      if (div_ready === 1'b1) rdy_seen++;
    end
    reset_n = 1'b0;
    #1;
    total_cnt++; if (data_result !== 32'h0) $display("FAIL midreset_result got %h want 0", data_result); else pass_cnt++;
    total_cnt++; if (data_exception !== 1'b0) $display("FAIL midreset_exc got %b want 0", data_exception); else pass_cnt++;
    total_cnt++; if (div_running !== 1'b0) $display("FAIL midreset_running got %b want 0", div_running); else pass_cnt++;
    for (int cyc = 0; cyc < 2; cyc++) begin
      @(negedge clock);
      if (div_ready === 1'b1) rdy_seen++;
    end
    reset_n = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clock);
      if (div_ready === 1'b1) rdy_seen++;
    end
    total_cnt++; if (rdy_seen !== 0) $display("FAIL midreset_ready got %0d pulses want 0", rdy_seen); else pass_cnt++;
    last_res = 32'h0;
    test_op("after_reset", 32'd1000, 32'd10, 34, 32'd100, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_overflow();
    test_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
